uart_byte_tx: RTL and testbench
===============================

UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 2..65535.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 d_in  input  8  parallel byte to transmit; sampled only on acceptance.
REQ-005 in_valid  input  1  d_in holds a byte to send.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 tx  output  1  serial line; idles high.
REQ-008 busy  output  1  a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse marking the last cycle of a frame.

Function
REQ-010 The block SHALL transmit one frame per accepted byte: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); 10 bits total.
REQ-011 The block SHALL implement states IDLE, START, DATA, STOP; all other encodings SHALL return to IDLE on the next edge.
REQ-012 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; d_in SHALL be copied into an internal 8-bit shift register on that edge.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE and rst=0; busy SHALL be the inverse of in_ready while rst=0.
REQ-014 Transitions: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8*CLKS_PER_BIT cycles; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 tx SHALL go low in the first cycle after the accepting edge (latency 1 cycle) and each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-016 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
REQ-017 A 16-bit bit-timer SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; a 3-bit index SHALL count data bits 0..7.
REQ-018 tx_done SHALL be 1 only in the last cycle of the stop bit; it SHALL NOT be 1 in any other cycle.
REQ-019 In IDLE, tx SHALL be 1.
REQ-020 in_valid and d_in SHALL be ignored while busy=1; there is no buffering, and changes to d_in after acceptance SHALL NOT affect the frame in progress.
REQ-021 Back-to-back: if in_valid is held high, the next byte SHALL be accepted in the first IDLE cycle, giving exactly one idle-high cycle between consecutive stop and start bits.
REQ-022 in_valid=1 in IDLE with in_ready=1 SHALL always be accepted; no condition SHALL stall acceptance in IDLE.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force state=IDLE, tx=1, busy=0, tx_done=0, in_ready=0, bit-timer=0, index=0, and shift register=8'h00.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; the byte SHALL be discarded and not resumed.
REQ-025 After rst deasserts, in_ready SHALL be 1 from the next rising edge, with tx=1.

Verification
REQ-026 CLKS_PER_BIT=4; send 8'hA5 -> in_ready=0 during the frame; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_done pulses once in cycle 40 after acceptance.
REQ-027 Hold in_valid=1 with 8'h00 then 8'hFF -> two frames separated by exactly one tx=1 idle cycle; second frame is 0,1x8,1.
REQ-028 Change d_in from 8'h3C to 8'hC3 and pulse in_valid while busy -> the 8'h3C frame is unchanged; no second frame is sent.
REQ-029 Assert rst during data bit 3 of 8'h55 -> tx=1, busy=0, tx_done=0 in the same cycle; after release, a new 8'h81 frame is sent correctly.
REQ-030 CLKS_PER_BIT=2; send 8'h01 -> frame length is 20 cycles; bit 0 is high for cycles 3-4 after acceptance.

Source files
------------

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serial transmitter.
// Accepts a byte on a valid/ready handshake and sends start bit (0), eight
// data bits LSB first and a stop bit (1), each held CLKS_PER_BIT cycles.
// No buffering: while a frame is in flight the input handshake is closed.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Last value of the per-bit timer; the bit boundary is reached here.
    localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [2:0]  idx_reg,   idx_next;
    logic [7:0]  shift_reg, shift_next;

    logic bit_end;
    logic accept;
    logic tx_comb;
    logic done_comb;

    assign bit_end = (timer_reg == TIMER_LAST);

    // Handshake is open only in IDLE and never while reset is held, so the
    // ready/busy pair is gated by rst directly rather than waiting for a clock.
    assign in_ready = (state_reg == IDLE) && !rst;
    assign busy     = (state_reg != IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // State, bit-timer, data index and shift register; reset clears all of it,
    // which also discards any frame that was in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= 16'd0;
            idx_reg   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    // Next-state logic and line/pulse outputs decoded from the current state.
    always_comb begin
        state_next = state_reg;
        timer_next = bit_end ? 16'd0 : timer_reg + 16'd1;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_comb    = 1'b1;
        done_comb  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Timer is held at zero so the start bit gets a full period.
                timer_next = 16'd0;
                if (accept) begin
                    state_next = START;
                    shift_next = d_in;
                    idx_next   = 3'd0;
                end
            end
            START: begin
                tx_comb = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // Current data bit always sits in bit 0; shift at each boundary.
                tx_comb = shift_reg[0];
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                tx_comb = 1'b1;
                if (bit_end) begin
                    done_comb  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = 16'd0;
            end
        endcase
    end

    // Line forced idle-high and done suppressed whenever reset is asserted.
    assign tx      = rst ? 1'b1 : tx_comb;
    assign tx_done = done_comb && !rst;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx: directed scenarios plus randomized bytes,
// checked against a frame model built from the 8N1 framing rules.
module tb_uart_byte_tx;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic       in_valid;
    logic       sel;

    logic in_valid_a, in_ready_a, tx_a, busy_a, tx_done_a;
    logic in_valid_b, in_ready_b, tx_b, busy_b, tx_done_b;
    logic obs_ready, obs_tx, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;

    // sel=0 exercises the CLKS_PER_BIT=4 instance, sel=1 the CLKS_PER_BIT=2 one.
    assign in_valid_a = sel ? 1'b0 : in_valid;
    assign in_valid_b = sel ? in_valid : 1'b0;
    assign obs_ready  = sel ? in_ready_b : in_ready_a;
    assign obs_tx     = sel ? tx_b : tx_a;
    assign obs_busy   = sel ? busy_b : busy_a;
    assign obs_done   = sel ? tx_done_b : tx_done_a;

    uart_byte_tx u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .tx       (tx_a),
        .busy     (busy_a),
        .tx_done  (tx_done_a)
    );

    uart_byte_tx #(.CLKS_PER_BIT(2)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .tx       (tx_b),
        .busy     (busy_b),
        .tx_done  (tx_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return 1'((b >> (k - 1)) & 8'd1);
    endfunction

    // Waits (bounded) until the handshake is open, then consumes the accepting edge.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (obs_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(obs_ready), 32'd1);
        @(posedge clk);
    endtask

    // Checks cycles 1..ncyc after the accepting edge against the frame model.
    // noise: 0 leave inputs alone, 1 random valid/data, 2 pulse valid with 8'hC3.
    task automatic run_frame(input logic [7:0] b, input int cpb, input int ncyc, input int noise);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            chk($sformatf("tx byte=%0h c=%0d", b, c), 32'(obs_tx), 32'(frame_bit(b, (c - 1) / cpb)));
            chk($sformatf("busy c=%0d", c), 32'(obs_busy), 32'd1);
            chk($sformatf("ready c=%0d", c), 32'(obs_ready), 32'd0);
            chk($sformatf("done c=%0d", c), 32'(obs_done), 32'(c == 10 * cpb));
            if (noise != 0 && c == 10 * cpb) begin
                in_valid = 1'b0;
            end else if (noise == 1) begin
                in_valid = 1'($urandom_range(0, 1));
                d_in     = 8'($urandom);
            end else if (noise == 2) begin
                in_valid = (c % 3 == 0);
                d_in     = 8'hC3;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, 32'(obs_tx), 32'd1);
        chk({tag, "_busy"}, 32'(obs_busy), 32'd0);
        chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
        chk({tag, "_done"}, 32'(obs_done), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int gap;

        sel      = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        d_in     = 8'h00;

        // Reset state.
        @(negedge clk);
        chk("rst_tx", 32'(obs_tx), 32'd1);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        chk("rst_done", 32'(obs_done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(obs_ready), 32'd1);
        chk("post_rst_tx", 32'(obs_tx), 32'd1);

        // Single frame of 8'hA5.
        in_valid = 1'b1;
        d_in     = 8'hA5;
        wait_accept();
        #1;
        in_valid = 1'b0;
        d_in     = 8'h5A;
        run_frame(8'hA5, 4, 40, 0);
        @(negedge clk);
        chk_idle("a5_after");

        // Back-to-back with in_valid held: 8'h00 then 8'hFF.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        d_in     = 8'h00;
        wait_accept();
        #1;
        d_in = 8'hFF;
        run_frame(8'h00, 4, 40, 0);
        @(negedge clk);
        chk_idle("b2b_gap");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        run_frame(8'hFF, 4, 40, 0);
        @(negedge clk);
        chk_idle("ff_after");

        // Input changes and valid pulses while busy are ignored.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        d_in     = 8'h3C;
        wait_accept();
        #1;
        in_valid = 1'b0;
        d_in     = 8'hC3;
        run_frame(8'h3C, 4, 40, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("no_second_tx i=%0d", i), 32'(obs_tx), 32'd1);
            chk($sformatf("no_second_busy i=%0d", i), 32'(obs_busy), 32'd0);
        end

        // Reset during data bit 3 of 8'h55, then a clean 8'h81 frame.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        d_in     = 8'h55;
        wait_accept();
        #1;
        in_valid = 1'b0;
        run_frame(8'h55, 4, 18, 0);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(obs_tx), 32'd1);
        chk("abort_busy", 32'(obs_busy), 32'd0);
        chk("abort_done", 32'(obs_done), 32'd0);
        chk("abort_ready", 32'(obs_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_tx", 32'(obs_tx), 32'd1);
        chk("held_rst_busy", 32'(obs_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_ready", 32'(obs_ready), 32'd1);
        chk("rel_tx", 32'(obs_tx), 32'd1);
        in_valid = 1'b1;
        d_in     = 8'h81;
        wait_accept();
        #1;
        in_valid = 1'b0;
        run_frame(8'h81, 4, 40, 0);
        @(negedge clk);
        chk_idle("81_after");

        // Randomized bytes with random idle gaps and random noise while busy.
        for (int t = 0; t < 6; t++) begin
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("gap_tx t=%0d", t), 32'(obs_tx), 32'd1);
                chk($sformatf("gap_busy t=%0d", t), 32'(obs_busy), 32'd0);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            d_in     = b;
            wait_accept();
            #1;
            in_valid = 1'b0;
            run_frame(b, 4, 40, 1);
        end
        @(negedge clk);
        chk_idle("rand_after");

        // CLKS_PER_BIT=2 instance: 8'h01, 20-cycle frame.
        @(posedge clk);
        #1;
        sel      = 1'b1;
        in_valid = 1'b1;
        d_in     = 8'h01;
        wait_accept();
        #1;
        in_valid = 1'b0;
        run_frame(8'h01, 2, 20, 0);
        @(negedge clk);
        chk_idle("cpb2_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
